hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage forwarding core. Consumes the ID-stage source operands and the ID/EX register outputs (`is_load`, `rd_addr`, `rd_wren`), the EX-stage redirect and the LSU handshake. It drives the enable and clear inputs of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) to insert load-use bubbles, squash wrong-path instructions and freeze on memory wait. It also keeps saturating stall and flush counters.

## Interface
- `REDIRECT_BUBBLES`, default 1: number of cycles IF/ID is squashed after a redirect. Minimum 1.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk_i`  in  1  clock; all state is updated on its rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `id_rs1_addr_i`, `id_rs2_addr_i`  in  5  ID-stage source register addresses.
- `id_rs1_used_i`, `id_rs2_used_i`  in  1  the ID instruction actually reads rs1 / rs2.
- `ex_is_load_i`, `ex_rd_wren_i`  in  1  from the ID/EX register outputs.
- `ex_rd_addr_i`  in  5  from the ID/EX register outputs.
- `ex_redirect_i`  in  1  branch taken or jump resolved in EX.
- `mem_req_i`  in  1  EX/MEM holds a load or store.
- `mem_ready_i`  in  1  LSU completes the access this cycle.
- `pc_en_o`, `if_id_en_o`, `id_ex_en_o`, `ex_mem_en_o`, `mem_wb_en_o`  out  1  stage register enables.
- `if_id_clr_no`, `id_ex_clr_no`  out  1  active-low synchronous clear; ANDed with `rst_i` at the register.
- `hazard_state_o`  out  2  current FSM state.
- `stall_cnt_o`, `flush_cnt_o`  out  `CNT_W`  saturating event counters.

## Operation
- **Load-use hazard (`lu`):**
  - `lu` = `ex_is_load_i & ex_rd_wren_i & (ex_rd_addr_i != 0)`, AND
  - (`id_rs1_used_i` & match on rs1) OR (`id_rs2_used_i` & match on rs2).
  - A destination of x0 never stalls.
- **Freeze (`fz`):** `fz` = `mem_req_i & !mem_ready_i`.
- **Outputs are combinational** from the state and inputs, evaluated with this priority:
  1. `fz`: all five enables 0; both clears 1 (inactive). `stall_cnt` increments.
  2. Redirect (`ex_redirect_i` in RUN/MEM_WAIT):
     - All enables 1; `if_id_clr_no` = 0 and `id_ex_clr_no` = 0.
     - `flush_cnt` increments.
     - Load-use is ignored, because the ID instruction is squashed.
  3. `lu` (RUN/MEM_WAIT only):
     - `pc_en_o` = 0 and `if_id_en_o` = 0.
     - `id_ex_en_o` = 1 with `id_ex_clr_no` = 0, which inserts a bubble.
     - EX/MEM and MEM/WB enabled.
     - `stall_cnt` increments.
  4. Otherwise: all enables 1, clears 1.
- **State machine** (encoding in the package):
  - **HZ_RUN:**
    - `fz` → HZ_MEM_WAIT.
    - Redirect with `REDIRECT_BUBBLES` > 1 → HZ_REDIRECT, loading `bub_cnt` = `REDIRECT_BUBBLES`-1.
    - Anything else stays in HZ_RUN.
  - **HZ_MEM_WAIT:**
    - Stays while `fz`.
    - When `fz` drops, the same cycle is evaluated with the RUN rules, and the next state follows the RUN transitions.
  - **HZ_REDIRECT:**
    - Outputs: all enables 1 and `if_id_clr_no` = 0; `lu` is not evaluated.
    - `bub_cnt` decrements each non-frozen cycle; when it reaches 1 the FSM returns to HZ_RUN.
    - `fz` here holds `bub_cnt` and stays in HZ_REDIRECT.
    - `ex_redirect_i` here reloads `bub_cnt` and counts as a flush.
- **Counters:**
  - Increment by 1 per qualifying cycle and saturate at all-ones; they never wrap.
  - A cycle with both `fz` and a redirect counts only the stall.
- **Reset:**
  - While `rst_i` = 0: all enables 0; `if_id_clr_no` = 0 and `id_ex_clr_no` = 0.
  - State = HZ_RUN (`hazard_state_o` = 0), `bub_cnt` = 0, both counters 0.
  - A reset asserted mid-stall or mid-redirect aborts immediately.

## Timing
- Stall, flush and freeze decisions take effect at the clock edge ending the cycle in which the condition is seen; there is zero-cycle decision latency.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM and the dependency is resolved by MEM/WB forwarding.
- A redirect squashes the two younger instructions at that edge, plus `REDIRECT_BUBBLES`-1 further IF/ID slots.
- Freeze lasts until the first cycle with `mem_ready_i` = 1. That cycle advances normally.
- State, `bub_cnt` and the counters are registered. `hazard_state_o` and the counters reflect the registered values (one cycle after the event).

## Structure
- **`hazard_pkg`:**
  - `hazard_state_e` = {HZ_RUN=2'd0, HZ_MEM_WAIT=2'd1, HZ_REDIRECT=2'd2}.
  - Constant `REG_X0` = 5'd0.
- **Sub-module `sat_counter` #(`CNT_W`):**
  - Ports `clk_i`, `rst_i`, `inc_i`, `cnt_o`.
  - Async active-low clear; saturates at all-ones.
  - Instantiated twice, for the stall and flush counters.

## Test plan
- ID/EX = `lw x5` (`rd_wren` = 1), ID = `add x6,x5,x7` with rs1 used → for 1 cycle `pc_en_o` = 0, `if_id_en_o` = 0, `id_ex_clr_no` = 0; next cycle all enables 1; `stall_cnt_o` = 1.
- Same as above but `ex_rd_addr_i` = 0, or the matching source has its `_used` flag = 0 → no stall; `stall_cnt_o` stays 0.
- `ex_redirect_i` and `lu` asserted together, `REDIRECT_BUBBLES` = 3:
  - In the redirect cycle, both clears are 0 and `pc_en_o` = 1.
  - HZ_REDIRECT lasts 2 cycles with `if_id_clr_no` = 0, then HZ_RUN.
  - `flush_cnt_o` = 1 and `stall_cnt_o` = 0.
- `mem_req_i` = 1, `mem_ready_i` = 0 for 4 cycles:
  - All enables are 0 and the state is HZ_MEM_WAIT during those cycles.
  - The ready cycle advances with all enables 1.
  - `stall_cnt_o` = 4.
- `CNT_W` = 4 with 20 load-use stalls → `stall_cnt_o` saturates at 15.
- `rst_i` pulsed low during HZ_REDIRECT → outputs and counters immediately take their reset values, without waiting for a clock edge; after release the state is HZ_RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_pkg : shared types for the hazard controller  | rev 1.0   |
// +------------------------------------------------------------------+
package hazard_pkg;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_MEM_WAIT = 2'd1,
      HZ_REDIRECT = 2'd2
   } hazard_state_e;

   localparam logic [4:0] REG_X0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter : event counter that sticks at all-ones  | rev 1.0   |
// +------------------------------------------------------------------+
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
         cnt_o <= cnt_o + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl : load-use stall, redirect flush, memory freeze | 1.0 |
// +------------------------------------------------------------------+
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REDIRECT_BUBBLES = 1,
   parameter int CNT_W            = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic             ex_is_load_i,
   input  logic             ex_rd_wren_i,
   input  logic [4:0]       ex_rd_addr_i,
   input  logic             ex_redirect_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             pc_en_o,
   output logic             if_id_en_o,
   output logic             id_ex_en_o,
   output logic             ex_mem_en_o,
   output logic             mem_wb_en_o,
   output logic             if_id_clr_no,
   output logic             id_ex_clr_no,
   output logic [1:0]       hazard_state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int               BUB_W        = $clog2(REDIRECT_BUBBLES + 1);
   localparam logic [BUB_W-1:0] BUB_RELOAD   = BUB_W'(REDIRECT_BUBBLES - 1);
   localparam logic [BUB_W-1:0] BUB_ONE      = BUB_W'(1);
   localparam bit               MULTI_BUBBLE = (REDIRECT_BUBBLES > 1);

   hazard_state_e    state;
   hazard_state_e    next_state;
   logic [BUB_W-1:0] bub_cnt;
   logic [BUB_W-1:0] next_bub;
   logic             rs1_hit;
   logic             rs2_hit;
   logic             lu;
   logic             fz;
   logic             stall_inc;
   logic             flush_inc;

   assign rs1_hit = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
   assign rs2_hit = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
   assign lu      = ex_is_load_i && ex_rd_wren_i && (ex_rd_addr_i != REG_X0)
                    && (rs1_hit || rs2_hit);
   assign fz      = mem_req_i && !mem_ready_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= HZ_RUN;
         bub_cnt <= '0;
      end else begin
         state   <= next_state;
         bub_cnt <= next_bub;
      end
   end

   always_comb begin
      next_state   = state;
      next_bub     = bub_cnt;
      pc_en_o      = 1'b1;
      if_id_en_o   = 1'b1;
      id_ex_en_o   = 1'b1;
      ex_mem_en_o  = 1'b1;
      mem_wb_en_o  = 1'b1;
      if_id_clr_no = 1'b1;
      id_ex_clr_no = 1'b1;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;

      if (fz) begin
         // Freeze outranks everything; a pending redirect is replayed once the LSU answers.
         pc_en_o     = 1'b0;
         if_id_en_o  = 1'b0;
         id_ex_en_o  = 1'b0;
         ex_mem_en_o = 1'b0;
         mem_wb_en_o = 1'b0;
         stall_inc   = 1'b1;
         if (state != HZ_REDIRECT) begin
            next_state = HZ_MEM_WAIT;
         end
      end else if (state == HZ_REDIRECT) begin
         if_id_clr_no = 1'b0;
         if (ex_redirect_i) begin
            id_ex_clr_no = 1'b0;
            flush_inc    = 1'b1;
            next_bub     = BUB_RELOAD;
         end else if (bub_cnt <= BUB_ONE) begin
            next_state = HZ_RUN;
            next_bub   = '0;
         end else begin
            next_bub = bub_cnt - BUB_ONE;
         end
      end else begin
         // RUN, and MEM_WAIT on the cycle the access completes, share these rules.
         next_state = HZ_RUN;
         if (ex_redirect_i) begin
            if_id_clr_no = 1'b0;
            id_ex_clr_no = 1'b0;
            flush_inc    = 1'b1;
            if (MULTI_BUBBLE) begin
               next_state = HZ_REDIRECT;
               next_bub   = BUB_RELOAD;
            end
         end else if (lu) begin
            pc_en_o      = 1'b0;
            if_id_en_o   = 1'b0;
            id_ex_clr_no = 1'b0;
            stall_inc    = 1'b1;
         end
      end

      if (!rst_i) begin
         pc_en_o      = 1'b0;
         if_id_en_o   = 1'b0;
         id_ex_en_o   = 1'b0;
         ex_mem_en_o  = 1'b0;
         mem_wb_en_o  = 1'b0;
         if_id_clr_no = 1'b0;
         id_ex_clr_no = 1'b0;
      end
   end

   assign hazard_state_o = state;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (flush_inc),
      .cnt_o (flush_cnt_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hazard_ctrl : directed self-checking bench        | rev 1.0   |
// +------------------------------------------------------------------+
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1_addr, rs2_addr, rd_addr;
   logic       rs1_used, rs2_used, is_load, rd_wren, redirect, mem_req, mem_ready;

   // dut0: three redirect bubbles, 4-bit counters; dut1: defaults
   logic        pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, mem_wb_en0, if_id_clr0, id_ex_clr0;
   logic [1:0]  state0;
   logic [3:0]  stall0, flush0;
   logic        pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1, if_id_clr1, id_ex_clr1;
   logic [1:0]  state1;
   logic [15:0] stall1, flush1;
   logic [4:0]  en0, en1;
   logic [1:0]  clr0;

   int n_checks = 0;
   int n_pass   = 0;

   assign en0  = {pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, mem_wb_en0};
   assign en1  = {pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1};
   assign clr0 = {if_id_clr0, id_ex_clr0};

   always #5 clk = ~clk;

   hazard_ctrl #(.REDIRECT_BUBBLES(3), .CNT_W(4)) u_dut0 (
      .clk_i(clk), .rst_i(rst_n),
      .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr),
      .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
      .ex_is_load_i(is_load), .ex_rd_wren_i(rd_wren), .ex_rd_addr_i(rd_addr),
      .ex_redirect_i(redirect), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .pc_en_o(pc_en0), .if_id_en_o(if_id_en0), .id_ex_en_o(id_ex_en0),
      .ex_mem_en_o(ex_mem_en0), .mem_wb_en_o(mem_wb_en0),
      .if_id_clr_no(if_id_clr0), .id_ex_clr_no(id_ex_clr0),
      .hazard_state_o(state0), .stall_cnt_o(stall0), .flush_cnt_o(flush0)
   );

   hazard_ctrl u_dut1 (
      .clk_i(clk), .rst_i(rst_n),
      .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr),
      .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
      .ex_is_load_i(is_load), .ex_rd_wren_i(rd_wren), .ex_rd_addr_i(rd_addr),
      .ex_redirect_i(redirect), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .pc_en_o(pc_en1), .if_id_en_o(if_id_en1), .id_ex_en_o(id_ex_en1),
      .ex_mem_en_o(ex_mem_en1), .mem_wb_en_o(mem_wb_en1),
      .if_id_clr_no(if_id_clr1), .id_ex_clr_no(id_ex_clr1),
      .hazard_state_o(state1), .stall_cnt_o(stall1), .flush_cnt_o(flush1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
      rs1_used = 1'b0; rs2_used = 1'b0; is_load = 1'b0; rd_wren = 1'b0;
      redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   // ID/EX holds lw x<rd>, ID reads rs1/rs2 with the given used flags
   task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2);
      is_load = 1'b1; rd_wren = 1'b1; rd_addr = rd;
      rs1_addr = r1; rs1_used = u1; rs2_addr = r2; rs2_used = u2;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      set_idle();
      repeat (2) tick();
      check("rst_en", 32'(en0), 32'h00);
      check("rst_clr", 32'(clr0), 32'h0);
      check("rst_state", 32'(state0), 32'd0);
      check("rst_stall", 32'(stall0), 32'd0);
      check("rst_flush", 32'(flush0), 32'd0);
      rst_n = 1'b1;
      #1;
      check("run_en", 32'(en0), 32'h1F);
      check("run_clr", 32'(clr0), 32'h3);

      // lw x5 ; add x6,x5,x7
      set_lu(5'd5, 5'd5, 1'b1, 5'd7, 1'b1);
      #1;
      check("lu1_en", 32'(en0), 32'h07);
      check("lu1_clr", 32'(clr0), 32'h2);
      tick();
      is_load = 1'b0;
      #1;
      check("lu1_next_en", 32'(en0), 32'h1F);
      check("lu1_next_clr", 32'(clr0), 32'h3);
      check("lu1_stall", 32'(stall0), 32'd1);

      // non-stalling look-alikes
      set_lu(5'd0, 5'd0, 1'b1, 5'd7, 1'b1);
      #1;
      check("x0_en", 32'(en0), 32'h1F);
      set_lu(5'd5, 5'd5, 1'b0, 5'd7, 1'b1);
      #1;
      check("unused_en", 32'(en0), 32'h1F);
      rd_wren = 1'b0;
      rs1_used = 1'b1;
      #1;
      check("nowren_en", 32'(en0), 32'h1F);
      tick();
      check("nostall_cnt", 32'(stall0), 32'd1);

      // match on rs2 only
      set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
      #1;
      check("lu2_en", 32'(en0), 32'h07);
      tick();
      set_idle();
      #1;
      check("lu2_stall", 32'(stall0), 32'd2);

      // redirect together with load-use
      set_lu(5'd5, 5'd5, 1'b1, 5'd7, 1'b1);
      redirect = 1'b1;
      #1;
      check("rd_en", 32'(en0), 32'h1F);
      check("rd_clr", 32'(clr0), 32'h0);
      tick();
      redirect = 1'b0;
      #1;
      check("rd_b1_state", 32'(state0), 32'd2);
      check("rd_b1_en", 32'(en0), 32'h1F);
      check("rd_b1_clr", 32'(clr0), 32'h1);
      check("rd1_state", 32'(state1), 32'd0);
      check("rd1_lu_en", 32'(en1), 32'h07);
      tick();
      check("rd_b2_state", 32'(state0), 32'd2);
      check("rd_b2_clr", 32'(clr0), 32'h1);
      tick();
      set_idle();
      #1;
      check("rd_done_state", 32'(state0), 32'd0);
      check("rd_done_en", 32'(en0), 32'h1F);
      check("rd_flush", 32'(flush0), 32'd1);
      check("rd_stall", 32'(stall0), 32'd2);
      check("rd1_flush", 32'(flush1), 32'd1);
      check("rd1_stall", 32'(stall1), 32'd4);

      // 4-cycle memory freeze
      reset_pulse();
      mem_req = 1'b1;
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("fz_en", 32'(en0), 32'h00);
         check("fz_clr", 32'(clr0), 32'h3);
         tick();
         check("fz_state", 32'(state0), 32'd1);
      end
      mem_ready = 1'b1;
      #1;
      check("fz_rel_en", 32'(en0), 32'h1F);
      tick();
      set_idle();
      #1;
      check("fz_rel_state", 32'(state0), 32'd0);
      check("fz_stall", 32'(stall0), 32'd4);

      // freeze + redirect: stall only, redirect replays on the ready cycle
      mem_req = 1'b1; mem_ready = 1'b0; redirect = 1'b1;
      #1;
      check("fzrd_en", 32'(en0), 32'h00);
      tick();
      check("fzrd_state", 32'(state0), 32'd1);
      check("fzrd_stall", 32'(stall0), 32'd5);
      check("fzrd_flush", 32'(flush0), 32'd0);
      mem_ready = 1'b1;
      #1;
      check("fzrd_rel_clr", 32'(clr0), 32'h0);
      tick();
      check("fzrd_redir_state", 32'(state0), 32'd2);
      check("fzrd_redir_flush", 32'(flush0), 32'd1);
      redirect = 1'b0; mem_ready = 1'b0;
      #1;
      check("rdfz_en", 32'(en0), 32'h00);
      tick();
      set_idle();
      #1;
      check("rdfz_hold_state", 32'(state0), 32'd2);
      check("rdfz_stall", 32'(stall0), 32'd6);
      tick();
      check("rdfz_b2_state", 32'(state0), 32'd2);
      tick();
      check("rdfz_exit_state", 32'(state0), 32'd0);

      // counter saturation
      reset_pulse();
      set_lu(5'd5, 5'd5, 1'b1, 5'd7, 1'b1);
      repeat (20) tick();
      set_idle();
      #1;
      check("sat_stall4", 32'(stall0), 32'd15);
      check("sat_stall16", 32'(stall1), 32'd20);

      // asynchronous reset while in HZ_REDIRECT
      redirect = 1'b1;
      tick();
      redirect = 1'b0;
      #1;
      check("ar_pre_state", 32'(state0), 32'd2);
      rst_n = 1'b0;
      #1;
      check("ar_en", 32'(en0), 32'h00);
      check("ar_clr", 32'(clr0), 32'h0);
      check("ar_state", 32'(state0), 32'd0);
      check("ar_stall", 32'(stall0), 32'd0);
      check("ar_flush", 32'(flush0), 32'd0);
      rst_n = 1'b1;
      tick();
      check("ar_post_state", 32'(state0), 32'd0);
      check("ar_post_en", 32'(en0), 32'h1F);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
